// File: rtl/mst_data_chk_mc.sv
// Multi-channel incrementing-pattern checker with per-channel sticky error and saturating count.
// Optional first-mismatch capture ports are enabled by defining MST_DATA_CHK_CAPTURE_EN.
module mst_data_chk_mc #(
   parameter int DW  = 16,
   parameter int NCH = 4,
   parameter int CIW = 2,
   parameter int CW  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              erdis,
   input  logic              clr,
   input  logic              resync,
   input  logic              vld,
   input  logic [CIW-1:0]    ch_id,
   input  logic [DW-1:0]     rdata,
   output logic [NCH-1:0]    seq_err,
   output logic              any_err,
   output logic [NCH*CW-1:0] err_cnt
`ifdef MST_DATA_CHK_CAPTURE_EN
   ,
   output logic              cap_vld,
   output logic [CIW-1:0]    cap_ch,
   output logic [DW-1:0]     cap_exp,
   output logic [DW-1:0]     cap_got
`endif
);

   typedef enum logic {CHK, HALT} ch_state_e;

   ch_state_e         state_q [NCH];
   ch_state_e         state_d [NCH];
   logic [DW-1:0]     exp_q   [NCH];
   logic [DW-1:0]     exp_d   [NCH];
   logic [CW-1:0]     cnt_q   [NCH];
   logic [CW-1:0]     cnt_d   [NCH];
   logic [NCH-1:0]    err_q;
   logic [NCH-1:0]    err_d;

`ifdef MST_DATA_CHK_CAPTURE_EN
   logic              cap_vld_q, cap_vld_d;
   logic [CIW-1:0]    cap_ch_q,  cap_ch_d;
   logic [DW-1:0]     cap_exp_q, cap_exp_d;
   logic [DW-1:0]     cap_got_q, cap_got_d;
`endif

   // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
`ifdef MST_DATA_CHK_CAPTURE_EN
      cap_vld_d = cap_vld_q;
      cap_ch_d  = cap_ch_q;
      cap_exp_d = cap_exp_q;
      cap_got_d = cap_got_q;
`endif
      if (clr) begin
         for (int n = 0; n < NCH; n++) begin
            state_d[n] = CHK;
            exp_d[n]   = '0;
            cnt_d[n]   = '0;
         end
         err_d = '0;
`ifdef MST_DATA_CHK_CAPTURE_EN
         cap_vld_d = 1'b0;
         cap_ch_d  = '0;
         cap_exp_d = '0;
         cap_got_d = '0;
`endif
      end else if (vld && !erdis) begin
         // Ids at or above NCH match no channel, so such beats fall through untouched.
         for (int n = 0; n < NCH; n++) begin
            if (ch_id == CIW'(n) && state_q[n] == CHK) begin
               if (rdata == exp_q[n]) begin
                  exp_d[n] = exp_q[n] + 1'b1;
               end else begin
                  err_d[n] = 1'b1;
                  if (cnt_q[n] != '1) cnt_d[n] = cnt_q[n] + 1'b1;
                  if (resync) exp_d[n]   = rdata + 1'b1;
                  else        state_d[n] = HALT;
`ifdef MST_DATA_CHK_CAPTURE_EN
                  if (!cap_vld_q) begin
                     cap_vld_d = 1'b1;
                     cap_ch_d  = CIW'(n);
                     cap_exp_d = exp_q[n];
                     cap_got_d = rdata;
                  end
`endif
               end
            end
         end
      end
   end

   // NOTE: the per-channel arrays are small register files and must be reset, since the outputs depend on them directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < NCH; n++) begin
            state_q[n] <= CHK;
            exp_q[n]   <= '0;
            cnt_q[n]   <= '0;
         end
         err_q <= '0;
`ifdef MST_DATA_CHK_CAPTURE_EN
         cap_vld_q <= 1'b0;
         cap_ch_q  <= '0;
         cap_exp_q <= '0;
         cap_got_q <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignment keeps every register sampling pre-edge values.
         state_q <= state_d;
         exp_q   <= exp_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`ifdef MST_DATA_CHK_CAPTURE_EN
         cap_vld_q <= cap_vld_d;
         cap_ch_q  <= cap_ch_d;
         cap_exp_q <= cap_exp_d;
         cap_got_q <= cap_got_d;
`endif
      end
   end

   assign seq_err = err_q & {NCH{~erdis}};
   assign any_err = |seq_err;

   always_comb begin
      for (int n = 0; n < NCH; n++) err_cnt[n*CW +: CW] = cnt_q[n];
   end

`ifdef MST_DATA_CHK_CAPTURE_EN
   assign cap_vld = cap_vld_q;
   assign cap_ch  = cap_ch_q;
   assign cap_exp = cap_exp_q;
   assign cap_got = cap_got_q;
`endif

endmodule

// File: doc/mst_data_chk_mc.md
Name: mst_data_chk_mc

Overview:
Multi-channel streaming sequence checker for received FT-style data. It checks each channel's incrementing data pattern independently, with parametrised data width and channel count. Each channel has a sticky error flag and a saturating mismatch counter. Sits after the FIFO read path in the master test logic and feeds the status LEDs and register readback.

Parameters:
DW, 16, data word width in bits (>=2)
NCH, 4, number of channels checked (1..16)
CIW, 2, channel id width, must satisfy 2**CIW >= NCH
CW, 8, per-channel error counter width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
erdis  input  1  check disable; while high no channel state changes and seq_err outputs forced 0
clr  input  1  synchronous clear of all channel state (same values as reset)
resync  input  1  mode: 0 = halt channel on first error, 1 = resynchronise and keep counting
vld  input  1  rdata/ch_id valid this cycle
ch_id  input  CIW  channel of current beat
rdata  input  DW  received data word
seq_err  output  NCH  per-channel sticky error, gated by !erdis
any_err  output  1  OR of seq_err
err_cnt  output  NCH*CW  flattened per-channel mismatch counts, channel n at [n*CW +: CW]

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. All exp[n] = 0, err[n] = 0, cnt[n] = 0. Each channel's state = CHK. seq_err = 0, any_err = 0, err_cnt = 0.
- Per-channel state: CHK (checking) and HALT (stopped after error, halt mode only).
- A beat is accepted when vld=1, erdis=0, clr=0 and ch_id < NCH. Beats with ch_id >= NCH are ignored with no state change.
- Accepted beat on channel n in CHK:
  - match (rdata == exp[n]): exp[n] <= exp[n]+1 modulo 2**DW, so all-ones wraps to 0. err and cnt are unchanged.
  - mismatch: err[n] <= 1 and cnt[n] <= cnt[n]+1, saturating at all-ones. If resync=0, the channel goes to HALT and exp[n] holds. If resync=1, the channel stays in CHK and exp[n] <= rdata+1 modulo 2**DW.
- HALT: all beats for that channel are ignored. Exit is only via rst_n or clr. Changing resync to 1 does not release HALT.
- Latency: seq_err[n] and cnt[n] update on the clock edge that samples the offending beat, so they are visible the next cycle. seq_err[n] = err[n] & !erdis and any_err are combinational from registers.
- Priority: rst_n > clr > erdis > beat. clr concurrent with vld discards the beat.
- Only one channel updates per cycle. Other channels hold.
- erdis high mid-stream freezes exp/err/cnt. Checking resumes from the frozen exp when erdis drops.
- err_cnt is direct register output, unaffected by erdis.

Optional Feature:
Macro MST_DATA_CHK_CAPTURE_EN. When defined, these output ports are added:
- cap_vld (1)
- cap_ch (CIW)
- cap_exp (DW)
- cap_got (DW)

On the first mismatch after reset/clr (any channel), they latch channel, expected value and received value, and cap_vld is set. Later mismatches do not overwrite. Reset/clr returns all four to 0.
When not defined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- NCH=4, DW=16, resync=0: ch0 sends 0,1,2..,0x00FF -> seq_err=0, err_cnt=0, exp[0]=0x0100.
- ch1 sends 0,1,5,6: mismatch at 5 -> seq_err[1]=1 next cycle, cnt[1]=1. The 6 is ignored in HALT, so cnt stays 1. ch0/2/3 are unaffected.
- resync=1, ch2 sends 0,1,9,10,20: errors at 9 and 20 -> cnt[2]=2, exp[2]=21. seq_err[2] stays 1.
- Wrap: ch3 is driven 0..0xFFFF then 0 -> no error, exp[3]=1. Separately, CW=8 with 300 mismatches -> cnt saturates at 0xFF.
- erdis=1 with mismatching beats on all channels -> no state change and seq_err=0. Then erdis=0: the prior error reappears on seq_err. clr asserted with vld and bad data -> all state 0, beat discarded.
- With MST_DATA_CHK_CAPTURE_EN: ch1 expects 2 and gets 5, then ch3 gets a mismatch -> cap_ch=1, cap_exp=0x0002, cap_got=0x0005, cap_vld=1, unchanged by the ch3 error. ch_id=3 with NCH=3 -> ignored.
